// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter
//   Shift-register sequencer, BIT bits wide. At run time it is either a one-hot ring
//   or a twisted-ring (Johnson) counter, and it shifts right or left. It has a parallel
//   load, holds while en is low, and gives a registered wrap pulse when a step lands on
//   HOME. An illegal pattern is corrected to HOME on the next enabled edge, and that
//   edge also raises a registered illegal pulse.
//   All state changes happen on the falling edge of clk.
// Ports
//   clk      : clock (state updates on negedge)
//   clr      : synchronous active-high reset, sampled on the same negedge
//   en       : 1 = advance one step, 0 = hold
//   dir      : 0 = shift toward bit 0, 1 = shift toward MSB
//   mode     : 0 = ring (one-hot), 1 = Johnson
//   load     : parallel load of load_val (wins over en)
//   load_val : value to load
//   count    : counter state
//   wrap     : pulse, this edge's step produced HOME
//   illegal  : pulse, this edge replaced an illegal pattern with HOME
module ring_johnson_counter #(
  parameter int BIT = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  input  logic           dir,
  input  logic           mode,
  input  logic           load,
  input  logic [BIT-1:0] load_val,
  output logic [BIT-1:0] count,
  output logic           wrap,
  output logic           illegal
);

  localparam logic [BIT-1:0] ONE_C = BIT'(1);
  localparam logic [BIT-2:0] ONE_T = (BIT-1)'(1);

  logic [BIT-1:0] count_q, count_d, home, step;
  logic [BIT-2:0] trans;
  logic           wrap_q, wrap_d, ill_q, ill_d, legal;

  always_comb begin
    home  = mode ? '0 : {1'b1, {(BIT-1){1'b0}}};
    // One bit per adjacent pair that differs. A legal Johnson pattern has at most
    // one transition. A legal ring pattern has exactly one bit set. Both are
    // checked with the x & (x-1) single-bit test.
    trans = count_q[BIT-1:1] ^ count_q[BIT-2:0];
    if (mode) legal = (trans & (trans - ONE_T)) == '0;
    else      legal = (count_q != '0) && ((count_q & (count_q - ONE_C)) == '0);

    case ({mode, dir})
      2'b00:   step = {count_q[0], count_q[BIT-1:1]};
      2'b01:   step = {count_q[BIT-2:0], count_q[BIT-1]};
      2'b10:   step = {~count_q[0], count_q[BIT-1:1]};
      default: step = {count_q[BIT-2:0], ~count_q[BIT-1]};
    endcase

    count_d = count_q;
    wrap_d  = 1'b0;
    ill_d   = 1'b0;
    if (load) begin
      count_d = load_val;             // taken as-is, even when illegal
    end else if (en) begin
      if (legal) begin
        count_d = step;
        wrap_d  = (step == home);
      end else begin
        count_d = home;               // correction replaces the shift on this edge
        ill_d   = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (clr) begin
      count_q <= home;
      wrap_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ill_q   <= ill_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign illegal = ill_q;

endmodule
